// File: rtl/game_pkg.sv
// Shared game constants, message types and the deal sequencer state set.
// The block that imports this is built with DEAL_DETERMINISTIC_EN optional.
package game_pkg;

  localparam int NUM_CARDS   = 106;
  localparam int CARD_IDX_W  = 7;
  localparam int CARD_TYPE_W = 6;
  localparam int MSG_W       = 4;

  localparam logic [MSG_W-1:0] TABLE_TAKE  = 4'd0;
  localparam logic [MSG_W-1:0] HAND_DRAW   = 4'd4;
  localparam logic [MSG_W-1:0] STATE_CHEAT = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_SCAN,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_PEER,
    S_DONE
  } deal_state_e;

  // Folds a 7-bit random value into the card index range.
  function automatic logic [CARD_IDX_W-1:0] card_mod(
    input logic [CARD_IDX_W-1:0] v
  );
    if (v >= CARD_IDX_W'(NUM_CARDS))
      return v - CARD_IDX_W'(NUM_CARDS);
    return v;
  endfunction

endpackage

// File: rtl/deal_lfsr7.sv
// 7-bit Fibonacci LFSR (x^7+x^6+1); loads its seed while i_load is high.
// Shared by the deal sequencer and later random-draw logic.
module deal_lfsr7 #(
  parameter logic [6:0] SEED = 7'h5A
) (
  input  logic       clk,
  input  logic       i_load,
  output logic [6:0] o_value
);

  logic [6:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (i_load)
      r_lfsr <= SEED;
    else
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/init_deal_sequencer.sv
// Opening-deal sequencer: alternates draws with the peer board.
// Define DEAL_DETERMINISTIC_EN to always pick the lowest free card.
module init_deal_sequencer
  import game_pkg::*;
#(
  parameter int         PLAYER     = 0,
  parameter int         DEAL_TOTAL = 28,
  parameter logic [6:0] LFSR_SEED  = 7'h5A
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  input  logic                   start_game,
  input  logic [NUM_CARDS-1:0]   available_card,
  input  logic                   tx_done,
  input  logic                   peer_draw,
  output logic                   transmit,
  output logic                   ctrl_en,
  output logic [MSG_W-1:0]       ctrl_msg_type,
  output logic [CARD_TYPE_W-1:0] ctrl_card,
  output logic [CARD_IDX_W-1:0]  ctrl_card_idx,
  output logic [4:0]             deal_cnt,
  output logic                   busy,
  output logic                   deal_done,
  output logic                   deal_err
);

  localparam logic [4:0] TOTAL = 5'(DEAL_TOTAL);
  localparam logic       P_BIT = (PLAYER % 2) != 0;
  localparam logic [CARD_IDX_W-1:0] LAST =
    CARD_IDX_W'(NUM_CARDS - 1);

  deal_state_e r_state;
  deal_state_e w_next;

  logic                  w_rst;
  logic                  w_hit;
  logic [6:0]            w_lfsr;
  logic [CARD_IDX_W-1:0] w_start_ptr;
  logic [CARD_IDX_W-1:0] r_ptr;
  logic [CARD_IDX_W-1:0] r_left;
  logic [CARD_IDX_W-1:0] r_idx;
  logic [MSG_W-1:0]      r_msg;
  logic [4:0]            r_cnt;
  logic                  r_done;
  logic                  r_err;

  assign w_rst = !rst || interboard_rst;
  assign w_hit = available_card[r_ptr];

  deal_lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .i_load  (w_rst),
    .o_value (w_lfsr)
  );

`ifdef DEAL_DETERMINISTIC_EN
  assign w_start_ptr = '0;
`else
  assign w_start_ptr = card_mod(w_lfsr);
`endif

  always_ff @(posedge clk) begin
    if (w_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start_game) w_next = S_TURN;
      S_TURN:
        if (r_cnt == TOTAL)
          w_next = S_DONE;
        else if (r_cnt[0] == P_BIT)
          w_next = S_SCAN;
        else
          w_next = S_WAIT_PEER;
      S_SCAN:
        if (w_hit)
          w_next = S_SEND;
        else if (r_left == 7'd1)
          w_next = S_DONE;
      S_SEND:
        w_next = S_WAIT_ACK;
      S_WAIT_ACK:
        if (tx_done) w_next = S_TURN;
      S_WAIT_PEER:
        if (peer_draw) w_next = S_TURN;
      S_DONE:
        if (start_game) w_next = S_TURN;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_ptr  <= '0;
      r_left <= '0;
      r_idx  <= '0;
      r_msg  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE:
          if (start_game) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        S_TURN: begin
          r_ptr  <= w_start_ptr;
          r_left <= CARD_IDX_W'(NUM_CARDS);
          if (r_cnt == TOTAL) r_done <= 1'b1;
        end
        S_SCAN:
          if (w_hit) begin
            r_idx <= r_ptr;
            r_msg <= HAND_DRAW;
          end else begin
            r_ptr  <= (r_ptr == LAST) ? '0 : r_ptr + 7'd1;
            r_left <= r_left - 7'd1;
            if (r_left == 7'd1) r_err <= 1'b1;
          end
        S_WAIT_ACK:
          if (tx_done && r_cnt != TOTAL) r_cnt <= r_cnt + 5'd1;
        S_WAIT_PEER:
          if (peer_draw && r_cnt != TOTAL) r_cnt <= r_cnt + 5'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl_en  = 1'b0;
    transmit = 1'b0;
    busy     = 1'b1;
    unique case (r_state)
      S_IDLE, S_DONE: busy = 1'b0;
      S_SCAN:         transmit = 1'b1;
      S_SEND: begin
        transmit = 1'b1;
        ctrl_en  = 1'b1;
      end
      S_WAIT_ACK:     transmit = 1'b1;
      default: ;
    endcase
  end

  assign ctrl_msg_type = r_msg;
  assign ctrl_card_idx = r_idx;
  assign ctrl_card     = r_idx[CARD_IDX_W-1:1];
  assign deal_cnt      = r_cnt;
  assign deal_done     = r_done;
  assign deal_err      = r_err;

endmodule

// File: tb/tb_init_deal_sequencer.sv
// Bench for init_deal_sequencer: one PLAYER=0 and one PLAYER=1 instance.
// Picks are predicted from the deck and an LFSR reference model.
module tb_init_deal_sequencer;
  import game_pkg::*;

  localparam int         TOTAL = 28;
  localparam logic [6:0] SEED  = 7'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst   [2];
  logic         irst  [2];
  logic         sg    [2];
  logic         txd   [2];
  logic         peer  [2];
  logic [105:0] deck  [2];
  logic         trn   [2];
  logic         cen   [2];
  logic [3:0]   mtype [2];
  logic [5:0]   card  [2];
  logic [6:0]   idx   [2];
  logic [4:0]   cnt   [2];
  logic         busy  [2];
  logic         done  [2];
  logic         err   [2];

  init_deal_sequencer #(.PLAYER(0), .DEAL_TOTAL(TOTAL), .LFSR_SEED(SEED)) u0 (
    .clk(clk), .rst(rst[0]), .interboard_rst(irst[0]),
    .start_game(sg[0]), .available_card(deck[0]),
    .tx_done(txd[0]), .peer_draw(peer[0]),
    .transmit(trn[0]), .ctrl_en(cen[0]), .ctrl_msg_type(mtype[0]),
    .ctrl_card(card[0]), .ctrl_card_idx(idx[0]), .deal_cnt(cnt[0]),
    .busy(busy[0]), .deal_done(done[0]), .deal_err(err[0])
  );

  init_deal_sequencer #(.PLAYER(1), .DEAL_TOTAL(TOTAL), .LFSR_SEED(SEED)) u1 (
    .clk(clk), .rst(rst[1]), .interboard_rst(irst[1]),
    .start_game(sg[1]), .available_card(deck[1]),
    .tx_done(txd[1]), .peer_draw(peer[1]),
    .transmit(trn[1]), .ctrl_en(cen[1]), .ctrl_msg_type(mtype[1]),
    .ctrl_card(card[1]), .ctrl_card_idx(idx[1]), .deal_cnt(cnt[1]),
    .busy(busy[1]), .deal_done(done[1]), .deal_err(err[1])
  );

  // Reference LFSR: seed in reset, one polynomial step per clock otherwise.
  function automatic logic [6:0] lfsr_step(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  logic [6:0] m_lfsr [2];
  always @(posedge clk) begin
    m_lfsr[0] <= (!rst[0] || irst[0]) ? SEED : lfsr_step(m_lfsr[0]);
    m_lfsr[1] <= (!rst[1] || irst[1]) ? SEED : lfsr_step(m_lfsr[1]);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt [2];
  int n_pick  [2];
  bit seen    [2][106];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // which: 0 start_game, 1 tx_done, 2 peer_draw, 3 tx_done+peer_draw
  task automatic pulse(input int p, input int which);
    case (which)
      0: sg[p] = 1'b1;
      1: txd[p] = 1'b1;
      2: peer[p] = 1'b1;
      default: begin txd[p] = 1'b1; peer[p] = 1'b1; end
    endcase
    tick();
    sg[p] = 1'b0;
    txd[p] = 1'b0;
    peer[p] = 1'b0;
  endtask

  task automatic chk_zero(input int p, input string nm);
    chk(nm, {trn[p], cen[p], mtype[p], card[p], idx[p],
             cnt[p], busy[p], done[p], err[p]}, 0);
  endtask

  task automatic do_reset(input int p, input bit use_ib);
    if (use_ib) irst[p] = 1'b1;
    else        rst[p]  = 1'b0;
    tick();
    chk_zero(p, use_ib ? "ib_reset_outs" : "reset_outs");
    irst[p] = 1'b0;
    rst[p]  = 1'b1;
    exp_cnt[p] = 0;
    n_pick[p]  = 0;
    for (int i = 0; i < 106; i++) seen[p][i] = 1'b0;
  endtask

  // Entered at the negedge where the DUT sits in its turn-decision cycle.
  task automatic our_turn(input int p, input bit ack,
                          output int got, output bit was_err);
    int  start_i;
    int  d;
    int  k;
    bit  found;
`ifdef DEAL_DETERMINISTIC_EN
    start_i = 0;
`else
    start_i = int'(m_lfsr[p]) % 106;
`endif
    found = 1'b0;
    d = 0;
    for (int j = 0; j < 106; j++)
      if (!found && deck[p][(start_i + j) % 106]) begin
        found = 1'b1;
        d = j;
      end
    chk("turn_cnt", cnt[p], exp_cnt[p]);
    k = 0;
    got = -1;
    while (!cen[p] && !err[p] && k < 300) begin
      tick();
      k++;
      if (k == 1) chk("scan_transmit", trn[p], 1);
    end
    if (found) begin
      was_err = 1'b0;
      chk("pick_latency", k, d + 2);
      chk("pick_idx", idx[p], (start_i + d) % 106);
      chk("pick_card", card[p], ((start_i + d) % 106) / 2);
      chk("pick_msg", mtype[p], 4);
      chk("send_transmit", trn[p], 1);
      got = int'(idx[p]);
      chk("no_repeat", seen[p][idx[p]], 0);
      seen[p][idx[p]] = 1'b1;
      n_pick[p]++;
      deck[p][idx[p]] = 1'b0;
      tick();
      chk("strobe_one_shot", cen[p], 0);
      chk("idx_hold", idx[p], got);
      pulse(p, 2);
      chk("stray_peer_cnt", cnt[p], exp_cnt[p]);
      if (ack) begin
        pulse(p, 1);
        exp_cnt[p]++;
      end
    end else begin
      was_err = 1'b1;
      chk("err_latency", k, 107);
      chk("err_flag", err[p], 1);
      chk("err_done", done[p], 0);
      chk("err_busy", busy[p], 0);
      chk("err_no_send", cen[p], 0);
    end
  endtask

  task automatic peer_turn(input int p, input bit both);
    chk("turn_cnt", cnt[p], exp_cnt[p]);
    tick();
    chk("peer_transmit", trn[p], 0);
    chk("peer_busy", busy[p], 1);
    chk("peer_no_send", cen[p], 0);
    pulse(p, 1);
    chk("stray_tx_cnt", cnt[p], exp_cnt[p]);
    pulse(p, 0);
    chk("start_ignored", {busy[p], cnt[p]}, {1'b1, 5'(exp_cnt[p])});
    pulse(p, both ? 3 : 2);
    exp_cnt[p]++;
  endtask

  task automatic run_deal(input int p, input int upto);
    int  got;
    bit  e;
    while (exp_cnt[p] < upto) begin
      if (exp_cnt[p] % 2 == p) begin
        our_turn(p, 1'b1, got, e);
        if (e) return;
      end else begin
        peer_turn(p, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  typedef struct {
    int  bit_idx;
    bit  empty;
    int  exp_idx;
    int  exp_card;
    bit  exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int  got;
    bit  e;
    vecs[0] = '{0,   1'b0, 0,   0,  1'b0};
    vecs[1] = '{1,   1'b0, 1,   0,  1'b0};
    vecs[2] = '{57,  1'b0, 57,  28, 1'b0};
    vecs[3] = '{104, 1'b0, 104, 52, 1'b0};
    vecs[4] = '{105, 1'b0, 105, 52, 1'b0};
    vecs[5] = '{0,   1'b1, 0,   0,  1'b1};

    for (int p = 0; p < 2; p++) begin
      rst[p] = 1'b0; irst[p] = 1'b0; sg[p] = 1'b0;
      txd[p] = 1'b0; peer[p] = 1'b0; deck[p] = '0;
    end
    tick();
    tick();
    do_reset(0, 1'b0);
    do_reset(1, 1'b0);

    // Single-card and empty decks on our first turn.
    for (int v = 0; v < 6; v++) begin
      do_reset(0, v[0]);
      deck[0] = '0;
      if (!vecs[v].empty) deck[0][vecs[v].bit_idx] = 1'b1;
      pulse(0, 0);
      our_turn(0, 1'b0, got, e);
      chk("tbl_err", e, vecs[v].exp_err);
      if (!vecs[v].exp_err) begin
        chk("tbl_idx", got, vecs[v].exp_idx);
        chk("tbl_card", card[0], vecs[v].exp_card);
      end
    end

    // Full deal on a randomly holed deck, picked bits cleared as memory would.
    do_reset(0, 1'b0);
    deck[0] = '1;
    for (int i = 0; i < 30; i++) deck[0][$urandom_range(0, 105)] = 1'b0;
    pulse(0, 0);
    run_deal(0, TOTAL);
    chk("final_cnt", cnt[0], TOTAL);
    tick();
    chk("deal_done", done[0], 1);
    chk("deal_err_clear", err[0], 0);
    chk("done_busy", busy[0], 0);
    chk("done_transmit", trn[0], 0);
    chk("pick_count", n_pick[0], TOTAL / 2);
    pulse(0, 1);
    pulse(0, 2);
    chk("done_stray_cnt", cnt[0], TOTAL);
    pulse(0, 0);
    chk("restart", {cnt[0], done[0], busy[0]}, {5'd0, 1'b0, 1'b1});

    // Peer-first player, reset while awaiting our ack at deal_cnt=7.
    do_reset(1, 1'b0);
    deck[1] = '1;
    pulse(1, 0);
    run_deal(1, 7);
    our_turn(1, 1'b0, got, e);
    chk("pre_rst_cnt", cnt[1], 7);
    chk("pre_rst_transmit", trn[1], 1);
    rst[1] = 1'b0;
    tick();
    chk_zero(1, "mid_deal_reset");
    rst[1] = 1'b1;
    exp_cnt[1] = 0;
    n_pick[1] = 0;
    for (int i = 0; i < 106; i++) seen[1][i] = 1'b0;
    pulse(1, 0);
    chk("restart_after_rst", {cnt[1], busy[1]}, {5'd0, 1'b1});
    run_deal(1, 4);
    chk("p1_cnt_after_4", cnt[1], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
